// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive framer.
package rmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam logic [1:0] PRE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT = 2'b11;

    // Bytes held back so the 4 FCS bytes never leave plus one pending payload byte.
    localparam int unsigned FCS_DEPTH = 5;

    // Reflected CRC-32 advanced by one dibit, bit0 first.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_crc32_chk.sv
// Running CRC-32 over received data dibits; init wins over en.
module rmii_crc32_chk
    import rmii_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_q
);

    // CRC state register
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC32_INIT;
        end else if (init) begin
            crc_q <= CRC32_INIT;
        end else if (en) begin
            crc_q <= crc32_dibit(crc_q, dibit);
        end
    end

endmodule

// File: rtl/rmii_rx_frame.sv
// RMII 100M receive framer: preamble/SFD hunt, byte assembly, FCS strip and check.
module rmii_rx_frame
    import rmii_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned MIN_LEN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rmii_rxd,
    input  logic       rmii_crs_dv,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_sof,
    output logic       m_eof,
    output logic       m_crc_ok,
    output logic       m_err,
    output logic       rx_drop
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAXB = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_LEN);
    localparam logic [2:0]       FILL_FULL = 3'(FCS_DEPTH);

    rx_state_t         state;
    logic [1:0]        rxd_d1, rxd_d2;
    logic              dv_d1, dv_d2;
    logic [1:0]        phase;
    logic [5:0]        asm_q;
    logic [4:0][7:0]   fcs_buf;
    logic [2:0]        fill;
    logic [CNT_W-1:0]  byte_cnt;
    logic              emitted;
    logic [31:0]       crc_q;

    logic              pair_low;
    logic              data_acc;
    logic              frame_end;
    logic              sfd_hit;
    logic [7:0]        byte_new;

    // Two-deep input pipeline; d1 is the lookahead for crs_dv toggle detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_d1 <= 2'b00;
            rxd_d2 <= 2'b00;
            dv_d1  <= 1'b0;
            dv_d2  <= 1'b0;
        end else begin
            rxd_d1 <= rmii_rxd;
            rxd_d2 <= rxd_d1;
            dv_d1  <= rmii_crs_dv;
            dv_d2  <= dv_d1;
        end
    end

    // Sample classification: a lone low crs_dv is a toggle and still carries data
    always_comb begin
        pair_low  = !dv_d2 && !dv_d1;
        data_acc  = (state == ST_DATA) && !pair_low;
        frame_end = (state == ST_DATA) && pair_low;
        sfd_hit   = (state == ST_PREAMBLE) && !pair_low && (rxd_d2 == SFD_DIBIT);
        byte_new  = {rxd_d2, asm_q};
    end

    rmii_crc32_chk u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (sfd_hit),
        .en    (data_acc),
        .dibit (rxd_d2),
        .crc_q (crc_q)
    );

    // Framing FSM, byte assembler, FCS holdback and registered beat outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            phase    <= 2'd0;
            asm_q    <= '0;
            fcs_buf  <= '0;
            fill     <= 3'd0;
            byte_cnt <= '0;
            emitted  <= 1'b0;
            m_data   <= 8'd0;
            m_valid  <= 1'b0;
            m_sof    <= 1'b0;
            m_eof    <= 1'b0;
            m_crc_ok <= 1'b0;
            m_err    <= 1'b0;
            rx_drop  <= 1'b0;
        end else begin
            m_data   <= 8'd0;
            m_valid  <= 1'b0;
            m_sof    <= 1'b0;
            m_eof    <= 1'b0;
            m_crc_ok <= 1'b0;
            m_err    <= 1'b0;
            rx_drop  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (dv_d2 && rxd_d2 == PRE_DIBIT) begin
                        state <= ST_PREAMBLE;
                    end
                end

                ST_PREAMBLE: begin
                    if (pair_low) begin
                        state <= ST_IDLE;
                    end else if (rxd_d2 == SFD_DIBIT) begin
                        state    <= ST_DATA;
                        phase    <= 2'd0;
                        asm_q    <= '0;
                        fill     <= 3'd0;
                        byte_cnt <= '0;
                        emitted  <= 1'b0;
                    end else if (rxd_d2 != PRE_DIBIT) begin
                        state <= ST_WAIT_IDLE;
                    end
                end

                ST_DATA: begin
                    if (frame_end) begin
                        state <= ST_IDLE;
                        if (byte_cnt < CNT_MIN) begin
                            rx_drop <= 1'b1;
                        end else if (fill == FILL_FULL) begin
                            m_valid  <= 1'b1;
                            m_data   <= fcs_buf[4];
                            m_sof    <= !emitted;
                            m_eof    <= 1'b1;
                            m_crc_ok <= (crc_q == CRC32_RESIDUE);
                            m_err    <= (phase != 2'd0) || (byte_cnt > CNT_MAXB);
                        end
                    end else begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0:    asm_q[1:0] <= rxd_d2;
                            2'd1:    asm_q[3:2] <= rxd_d2;
                            2'd2:    asm_q[5:4] <= rxd_d2;
                            default: asm_q      <= asm_q;
                        endcase
                        if (phase == 2'd3) begin
                            if (byte_cnt != CNT_SAT) begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                            if (byte_cnt == CNT_MAXB) begin
                                // Oversize: close the frame on the oldest held byte
                                m_valid <= 1'b1;
                                m_data  <= fcs_buf[4];
                                m_sof   <= !emitted;
                                m_eof   <= 1'b1;
                                m_err   <= 1'b1;
                                emitted <= 1'b1;
                                state   <= ST_WAIT_IDLE;
                            end else if (fill == FILL_FULL) begin
                                m_valid <= 1'b1;
                                m_data  <= fcs_buf[4];
                                m_sof   <= !emitted;
                                emitted <= 1'b1;
                                fcs_buf <= {fcs_buf[3:0], byte_new};
                            end else begin
                                fcs_buf <= {fcs_buf[3:0], byte_new};
                                fill    <= fill + 3'd1;
                            end
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    if (pair_low) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_frame.sv
// Randomized + directed bench for rmii_rx_frame against a frame-level reference model.
module tb_rmii_rx_frame;

    localparam int unsigned MAX_LEN = 1522;
    localparam int unsigned MIN_LEN = 5;
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rmii_rxd;
    logic       rmii_crs_dv;
    logic [7:0] m_data;
    logic       m_valid, m_sof, m_eof, m_crc_ok, m_err, rx_drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  fb[$];
    logic [1:0]  fx[$];
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int          drop_exp;
    int          drop_obs;

    always #10 clk = ~clk;

    rmii_rx_frame #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .rmii_rxd    (rmii_rxd),
        .rmii_crs_dv (rmii_crs_dv),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_sof       (m_sof),
        .m_eof       (m_eof),
        .m_crc_ok    (m_crc_ok),
        .m_err       (m_err),
        .rx_drop     (rx_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Beat collector and flag qualification
    always @(negedge clk) begin
        if (m_valid) obs_q.push_back({m_data, m_sof, m_eof, m_crc_ok, m_err});
        if (rx_drop) drop_obs++;
        if (m_sof || m_eof) check("flag_needs_valid", 32'(m_valid), 1);
        if (m_crc_ok || m_err) check("status_needs_eof", 32'(m_valid && m_eof), 1);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] crc_feed(input logic [31:0] c, input logic [7:0] v, input int nbits);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < nbits; b++) r = (r[0] ^ v[b]) ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_of_bytes();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (fb[i]) c = crc_feed(c, fb[i], 8);
        return c;
    endfunction

    task automatic append_fcs();
        logic [31:0] f;
        f = ~crc_of_bytes();
        for (int k = 0; k < 4; k++) fb.push_back(f[8*k +: 8]);
    endtask

    // Frame-level expectation: hold back 4 FCS bytes, flag status on the last beat
    task automatic build_expected();
        int n, last;
        logic [31:0] c;
        logic ok, er;
        exp_q.delete();
        drop_exp = 0;
        n = fb.size();
        if (n < int'(MIN_LEN)) begin
            drop_exp = 1;
        end else if (n > int'(MAX_LEN)) begin
            last = int'(MAX_LEN) - 5;
            for (int i = 0; i <= last; i++)
                exp_q.push_back({fb[i], i == 0, i == last, 1'b0, i == last});
        end else begin
            c = crc_of_bytes();
            foreach (fx[j]) c = crc_feed(c, {6'd0, fx[j]}, 2);
            ok = (c == RESIDUE);
            er = (fx.size() != 0);
            last = n - 5;
            for (int i = 0; i <= last; i++)
                exp_q.push_back({fb[i], i == 0, i == last, (i == last) && ok, (i == last) && er});
        end
    endtask

    task automatic drive(input logic dv, input logic [1:0] d);
        @(negedge clk);
        rmii_crs_dv = dv;
        rmii_rxd    = d;
    endtask

    task automatic send_frame(input int lead, input int pre, input int tog, input int rst_byte);
        logic [1:0] d[$];
        logic [7:0] b;
        bit aborted;
        aborted = 0;
        foreach (fb[i]) begin
            b = fb[i];
            for (int k = 0; k < 4; k++) d.push_back(b[2*k +: 2]);
        end
        foreach (fx[i]) d.push_back(fx[i]);
        repeat (lead) drive(1'b1, 2'b00);
        repeat (pre) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int i = 0; i < d.size() && !aborted; i++) begin
            if (rst_byte >= 0 && i == rst_byte * 4) begin
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("reset_mid_outputs",
                      32'({m_data, m_valid, m_sof, m_eof, m_crc_ok, m_err, rx_drop}), 0);
                reset       = 1'b0;
                rmii_crs_dv = 1'b0;
                aborted     = 1;
            end else begin
                drive(i == tog ? 1'b0 : 1'b1, d[i]);
            end
        end
        repeat (10) drive(1'b0, 2'($urandom));
    endtask

    task automatic run_frame(input int lead, input int pre, input int tog, input int rst_byte);
        obs_q.delete();
        drop_obs = 0;
        build_expected();
        if (rst_byte >= 0) begin
            exp_q.delete();
            drop_exp = 0;
        end
        send_frame(lead, pre, tog, rst_byte);
        check("beat_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("beat%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
        check("drop_count", drop_obs, drop_exp);
    endtask

    function automatic logic last_crc_flag();
        logic [11:0] t;
        t = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 12'd0;
        return t[1];
    endfunction

    initial begin
        int p, n, ndib, tog;
        reset       = 1'b1;
        rmii_crs_dv = 1'b0;
        rmii_rxd    = 2'b00;
        @(negedge clk);
        check("reset_outputs", 32'({m_data, m_valid, m_sof, m_eof, m_crc_ok, m_err, rx_drop}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Known check value frame "123456789"
        fb.delete(); fx.delete();
        for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
        fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
        run_frame(0, 31, -1, -1);
        check("known_crc_ok", 32'(last_crc_flag()), 1);

        // Corrupted FCS
        fb[9] = 8'h27;
        run_frame(0, 31, -1, -1);
        check("bad_crc_flag", 32'(last_crc_flag()), 0);

        // 60-byte frame with a crs_dv toggle mid-data
        fb.delete(); fx.delete();
        for (int i = 0; i < 60; i++) fb.push_back(8'(i));
        append_fcs();
        run_frame(2, 31, 100, -1);

        // Runt frame
        fb.delete(); fx.delete();
        for (int i = 0; i < 4; i++) fb.push_back(8'($urandom));
        run_frame(0, 31, -1, -1);

        // Dribble dibit
        fb.delete(); fx.delete();
        for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
        append_fcs();
        fx.push_back(2'b10);
        run_frame(0, 31, -1, -1);

        // Oversize
        fb.delete(); fx.delete();
        for (int i = 0; i < 1600; i++) fb.push_back(8'($urandom));
        run_frame(0, 31, -1, -1);

        // Reset mid-frame then clean frame
        fb.delete(); fx.delete();
        for (int i = 0; i < 20; i++) fb.push_back(8'($urandom));
        append_fcs();
        run_frame(0, 31, -1, 5);
        run_frame(0, 31, -1, -1);
        check("post_reset_crc_ok", 32'(last_crc_flag()), 1);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            fb.delete(); fx.delete();
            if ($urandom_range(0, 99) < 15) begin
                n = $urandom_range(0, 4);
                for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            end else begin
                p = $urandom_range(1, 60);
                for (int i = 0; i < p; i++) fb.push_back(8'($urandom));
                append_fcs();
                if ($urandom_range(0, 99) < 25) begin
                    n = $urandom_range(0, fb.size() - 1);
                    fb[n] = fb[n] ^ 8'($urandom_range(1, 255));
                end
            end
            if ($urandom_range(0, 99) < 20) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) fx.push_back(2'($urandom));
            end
            ndib = fb.size() * 4 + fx.size();
            tog = -1;
            if (ndib >= 2 && $urandom_range(0, 99) < 30) tog = $urandom_range(0, ndib - 2);
            run_frame($urandom_range(0, 3), $urandom_range(1, 31), tog, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
